serial_add_ctrl: RTL and testbench

- Bit-serial add/subtract sequencer that time-shares one 1-bit adder cell over WIDTH cycles.
- The cell is two HALF_ADDER instances plus an OR for carry.
- Gives an area-minimal alternative to the ripple adder in the ALU datapath.
- Accepts operands on a START handshake, shifts them through the cell LSB-first, and reports the sum, carry-out and a one-cycle DONE pulse.

---
 rtl/half_adder.sv | 15 +
 rtl/serial_add_ctrl.sv | 101 ++++++++++
 tb/tb_serial_add_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/half_adder.sv
// rtl/half_adder.sv - one-bit half adder used by the serial adder cell
// Ports: a, b  - input bits
//        s     - sum (a ^ b)
//        c     - carry (a & b)
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial add/subtract sequencer over one 1-bit adder cell
// Ports: CLK   - rising-edge clock
//        RST   - asynchronous active-high reset
//        START - request, sampled only while idle
//        SUB   - 0: A+B, 1: A-B (sampled with START)
//        A, B  - operands (sampled with START)
//        BUSY  - operation in progress
//        DONE  - one-cycle pulse, Y/CO valid
//        Y     - sum/difference
//        CO    - carry-out of MSB (for subtract: 1 = no borrow)
//        OV    - signed overflow, present only when SERIAL_ADD_OVERFLOW_EN is defined
module serial_add_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             SUB,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] Y,
  output logic             CO
`ifdef SERIAL_ADD_OVERFLOW_EN
  ,
  output logic             OV
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic             carry;

  logic s_lo, c_lo, sum_bit, c_hi, carry_next;

  // Full-adder cell built from two half adders; OR merges their carries.
  half_adder u_ha_lo (.a(sa[0]), .b(sb[0]), .s(s_lo),    .c(c_lo));
  half_adder u_ha_hi (.a(s_lo),  .b(carry), .s(sum_bit), .c(c_hi));
  assign carry_next = c_lo | c_hi;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      sa    <= '0;
      sb    <= '0;
      carry <= 1'b0;
      Y     <= '0;
      CO    <= 1'b0;
`ifdef SERIAL_ADD_OVERFLOW_EN
      OV    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            sa    <= A;
            // Subtract as A + ~B + 1: invert B here, the +1 enters as carry-in.
            sb    <= B ^ {WIDTH{SUB}};
            carry <= SUB;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          Y     <= {sum_bit, Y[WIDTH-1:1]};
          carry <= carry_next;
          if (cnt == LAST_BIT) begin
            CO    <= carry_next;
`ifdef SERIAL_ADD_OVERFLOW_EN
            // carry holds the carry into the MSB during the last step.
            OV    <= carry ^ carry_next;
`endif
            state <= FIN;
          end else begin
            // Held at WIDTH-1 on the last step so the counter never wraps.
            cnt <= cnt + 1'b1;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign BUSY = (state != IDLE);
  assign DONE = (state == FIN);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - randomized self-checking bench for serial_add_ctrl
module tb_serial_add_ctrl;

  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         START = 1'b0;
  logic         SUB = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         BUSY, DONE, CO;
  logic [W-1:0] Y;
`ifdef SERIAL_ADD_OVERFLOW_EN
  logic         OV;
`endif

  serial_add_ctrl #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .START(START), .SUB(SUB), .A(A), .B(B),
    .BUSY(BUSY), .DONE(DONE), .Y(Y), .CO(CO)
`ifdef SERIAL_ADD_OVERFLOW_EN
    , .OV(OV)
`endif
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  always @(posedge CLK) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: result from plain arithmetic, timing from a busy countdown.
  int           m_left = 0;
  logic         m_valid = 1'b0;
  logic [W-1:0] m_y = '0;
  logic         m_co = 1'b0, m_ov = 1'b0;
  logic [W-1:0] p_y;
  logic         p_co, p_ov;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_left  = 0;
      m_y     = '0;
      m_co    = 1'b0;
      m_ov    = 1'b0;
      m_valid = 1'b1;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 1) begin
        m_y     = p_y;
        m_co    = p_co;
        m_ov    = p_ov;
        m_valid = 1'b1;
      end
    end else if (START) begin
      if (SUB) begin
        p_y  = A - B;
        p_co = (A >= B);
        p_ov = (A[W-1] != B[W-1]) && (p_y[W-1] != A[W-1]);
      end else begin
        {p_co, p_y} = {1'b0, A} + {1'b0, B};
        p_ov = (A[W-1] == B[W-1]) && (p_y[W-1] != A[W-1]);
      end
      m_left  = W + 1;
      m_valid = 1'b0;
    end
  end

  always @(negedge CLK) begin
    check("busy", BUSY, m_left > 0);
    check("done", DONE, m_left == 1);
    if (m_valid) begin
      check("y", Y, m_y);
      check("co", CO, m_co);
`ifdef SERIAL_ADD_OVERFLOW_EN
      check("ov", OV, m_ov);
`endif
    end
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input logic [W-1:0] ey, input logic eco, input logic eov);
    int lat;
    int busy_n;
    @(negedge CLK);
    START = 1'b1; SUB = sub; A = a; B = b;
    @(negedge CLK);
    START = 1'b0;
    lat = 1;
    busy_n = BUSY ? 1 : 0;
    while (!DONE && lat < W + 5) begin
      @(negedge CLK);
      lat++;
      if (BUSY) busy_n++;
    end
    check("latency", lat, W + 1);
    check("busy_cycles", busy_n, W + 1);
    check("op_y", Y, ey);
    check("op_co", CO, eco);
`ifdef SERIAL_ADD_OVERFLOW_EN
    check("op_ov", OV, eov);
`else
    if (eov === 1'bx) $display("unexpected x");
`endif
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!DONE && n < W + 10) begin
      @(negedge CLK);
      n++;
    end
    if (!DONE) check(name, 0, 1);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom % 5)
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int dones;
    int t1, t2;

    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("rst_busy", BUSY, 1'b0);
    check("rst_y", Y, 0);
    RST = 1'b0;

    run_op(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_op(32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_op(32'd7, 32'd5, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

    // Request while busy must be ignored.
    @(negedge CLK);
    START = 1'b1; SUB = 1'b0; A = 32'd3; B = 32'd4;
    @(negedge CLK);
    START = 1'b0;
    repeat (8) @(negedge CLK);
    START = 1'b1; A = 32'd100; B = 32'd100;
    @(negedge CLK);
    START = 1'b0;
    dones = 0;
    repeat (W + 8) begin
      @(negedge CLK);
      if (DONE) dones++;
    end
    check("ignored_dones", dones, 1);
    check("ignored_y", Y, 32'd7);

    // Asynchronous reset in the middle of a run.
    @(negedge CLK);
    START = 1'b1; A = 32'h1234_5678; B = 32'h0F0F_0F0F;
    @(negedge CLK);
    START = 1'b0;
    repeat (11) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    check("abort_busy", BUSY, 1'b0);
    check("abort_done", DONE, 1'b0);
    check("abort_y", Y, 0);
    check("abort_co", CO, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    dones = 0;
    repeat (W + 5) begin
      @(negedge CLK);
      if (DONE) dones++;
    end
    check("abort_no_done", dones, 0);
    run_op(32'h10, 32'h20, 1'b0, 32'h30, 1'b0, 1'b0);

    // Back-to-back with START held high.
    @(negedge CLK);
    START = 1'b1; SUB = 1'b0; A = 32'd1; B = 32'd2;
    @(negedge CLK);
    A = 32'd3; B = 32'd4;
    wait_done("b2b_timeout1");
    t1 = cyc;
    check("b2b_y1", Y, 32'd3);
    @(negedge CLK);
    check("b2b_hold", Y, 32'd3);
    wait_done("b2b_timeout2");
    t2 = cyc;
    START = 1'b0;
    check("b2b_spacing", t2 - t1, W + 2);
    check("b2b_y2", Y, 32'd7);
    repeat (4) @(negedge CLK);

    // Randomized traffic with occasional asynchronous resets.
    repeat (3000) begin
      @(negedge CLK);
      #1;
      START = ($urandom % 4 == 0);
      SUB   = 1'($urandom);
      A     = pick();
      B     = pick();
      RST   = ($urandom % 300 == 0);
    end
    #1 RST = 1'b0;
    START = 1'b0;
    repeat (W + 5) @(negedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
